// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared encodings and FSM state type for the 4-bit CPU sequencer
package cpu_pkg;
    localparam int REG_IDX_W = 2;

    localparam logic [1:0] CLS_ALU = 2'b00;
    localparam logic [1:0] CLS_LDI = 2'b01;
    localparam logic [1:0] CLS_JMP = 2'b10;
    localparam logic [1:0] CLS_SYS = 2'b11;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_OR  = 2'b01;
    localparam logic [1:0] ALU_XOR = 2'b10;
    localparam logic [1:0] ALU_NOT = 2'b11;

    localparam logic [1:0] SYS_JZ   = 2'b00;
    localparam logic [1:0] SYS_HALT = 2'b01;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_WRITEBACK,
        S_HALT
`ifdef CPU_CONTROL_SINGLE_STEP_EN
        , S_PAUSE
`endif
    } state_t;
endpackage

// File: rtl/cpu_alu.sv
// rtl/cpu_alu.sv - combinational 4-bit ALU driven by the sequencer
module cpu_alu
    import cpu_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [1:0] control,
    output logic [3:0] result
);
    always_comb begin
        result = '0;
        case (control)
            ALU_ADD: result = a + b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            ALU_NOT: result = ~a;
            default: result = '0;
        endcase
    end
endmodule

// File: rtl/cpu_regfile.sv
// rtl/cpu_regfile.sv - 4x4-bit register file, one write port, rd/rs/dbg read ports
module cpu_regfile
    import cpu_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 we,
    input  logic [REG_IDX_W-1:0] waddr,
    input  logic [3:0]           wdata,
    input  logic [REG_IDX_W-1:0] rd_addr,
    input  logic [REG_IDX_W-1:0] rs_addr,
    input  logic [REG_IDX_W-1:0] dbg_addr,
    output logic [3:0]           rd_data,
    output logic [3:0]           rs_data,
    output logic [3:0]           dbg_data
);
    logic [3:0] regs [4];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) regs[i] <= '0;
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rd_data  = regs[rd_addr];
    assign rs_data  = regs[rs_addr];
    assign dbg_data = regs[dbg_addr];
endmodule

// File: rtl/cpu_control.sv
// rtl/cpu_control.sv - multi-cycle fetch/decode/execute/writeback sequencer; CPU_CONTROL_SINGLE_STEP_EN adds step input and PAUSE
module cpu_control
    import cpu_pkg::*;
#(
    parameter int              PC_W     = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
`ifdef CPU_CONTROL_SINGLE_STEP_EN
    input  logic            step,
`endif
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_valid,
    input  logic [7:0]      imem_data,
    output logic [3:0]      alu_a,
    output logic [3:0]      alu_b,
    output logic [1:0]      alu_control,
    input  logic [3:0]      alu_result,
    output logic            zero,
    output logic            halted,
    output logic [PC_W-1:0] pc,
    input  logic [1:0]      dbg_sel,
    output logic [3:0]      dbg_data
);
    state_t state, state_next;
    logic                 req_next;
    logic [7:0]           ir;
    logic [3:0]           result;
    logic [1:0]           cls, sub;
    logic [REG_IDX_W-1:0] rd_idx, rs_idx;
    logic [3:0]           rd_data, rs_data;
    logic                 rf_we, fetch_accept;

    assign cls    = ir[7:6];
    assign sub    = ir[5:4];
    // LDI carries its destination in the op field; ALU keeps it in [3:2]
    assign rd_idx = (cls == CLS_LDI) ? ir[5:4] : ir[3:2];
    assign rs_idx = ir[1:0];
    assign rf_we  = (state == S_WRITEBACK) && (cls == CLS_ALU || cls == CLS_LDI);
    assign fetch_accept = (state == S_FETCH) && imem_req && imem_valid;

    assign imem_addr = pc;
    assign halted    = (state == S_HALT);

    cpu_regfile u_regfile (
        .clk      (clk),
        .reset    (reset),
        .we       (rf_we),
        .waddr    (rd_idx),
        .wdata    (result),
        .rd_addr  (rd_idx),
        .rs_addr  (rs_idx),
        .dbg_addr (dbg_sel),
        .rd_data  (rd_data),
        .rs_data  (rs_data),
        .dbg_data (dbg_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_FETCH;
            imem_req <= 1'b0;
        end else begin
            state    <= state_next;
            imem_req <= req_next;
        end
    end

    // imem_req is registered, so it is raised on entry to FETCH and dropped after acceptance
    always_comb begin
        state_next = state;
        req_next   = imem_req;
        case (state)
            S_FETCH: begin
                if (fetch_accept) begin
                    state_next = S_DECODE;
                    req_next   = 1'b0;
                end else begin
                    req_next   = 1'b1;
                end
            end
            S_DECODE:  state_next = S_EXECUTE;
            S_EXECUTE: state_next = (cls == CLS_SYS && sub == SYS_HALT) ? S_HALT : S_WRITEBACK;
`ifdef CPU_CONTROL_SINGLE_STEP_EN
            S_WRITEBACK: state_next = S_PAUSE;
            S_PAUSE: begin
                if (step) begin
                    state_next = S_FETCH;
                    req_next   = 1'b1;
                end
            end
`else
            S_WRITEBACK: begin
                state_next = S_FETCH;
                req_next   = 1'b1;
            end
`endif
            S_HALT:  req_next = 1'b0;
            default: begin
                state_next = S_FETCH;
                req_next   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_PC;
            ir          <= '0;
            result      <= '0;
            zero        <= 1'b0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_control <= ALU_ADD;
        end else begin
            case (state)
                S_FETCH: begin
                    if (fetch_accept) begin
                        ir <= imem_data;
                        pc <= pc + PC_W'(1);
                    end
                end
                S_DECODE: begin
                    alu_a       <= rd_data;
                    alu_b       <= rs_data;
                    alu_control <= (cls == CLS_ALU) ? ir[5:4] : ALU_ADD;
                end
                S_EXECUTE: begin
                    case (cls)
                        CLS_ALU: result <= alu_result;
                        CLS_LDI: result <= ir[3:0];
                        CLS_JMP: pc <= PC_W'(ir[3:0]);
                        default: if (sub == SYS_JZ && zero) pc <= PC_W'(ir[3:0]);
                    endcase
                end
                S_WRITEBACK: if (rf_we) zero <= (result == 4'd0);
                default: ;
            endcase
        end
    end
endmodule
